// File: rtl/nexys_starship_monster_gen.sv
// Top-port monster spawner: paces spawns with a tick strobe and a free-running LFSR,
// and flags top_broken when a monster stays unshot past its timeout.
module nexys_starship_monster_gen #(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [8:0]  SPAWN_THRESH   = 9'd16,
    parameter logic [7:0]  COOLDOWN_TICKS = 8'd16,
    parameter logic [7:0]  TIMEOUT_TICKS  = 8'd200
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       tick,
    input  logic       shoot,
    output logic       top_monster_ctrl,
    output logic       top_broken,
    output logic [7:0] spawn_count,
    output logic [7:0] kill_count,
    output logic       q_MG_Idle,
    output logic       q_MG_Cool,
    output logic       q_MG_Armed,
    output logic       q_MG_Active,
    output logic       q_MG_Broken
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCool   = 3'd1,
        StArmed  = 3'd2,
        StActive = 3'd3,
        StBroken = 3'd4
    } state_t;

    state_t      state;
    logic [4:0]  state_oh;
    logic [7:0]  counter;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        spawn_hit;
    logic [7:0]  spawn_inc;
    logic [7:0]  kill_inc;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1; nonzero seed never reaches 0.
    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign spawn_hit = ({1'b0, lfsr[7:0]} < SPAWN_THRESH);
    assign spawn_inc = (spawn_count == 8'hFF) ? spawn_count : spawn_count + 8'd1;
    assign kill_inc  = (kill_count == 8'hFF) ? kill_count : kill_count + 8'd1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    // Bit order {Broken, Active, Armed, Cool, Idle}.
    function automatic logic [4:0] onehot(input state_t s);
        logic [4:0] v;
        v = 5'b00001;
        case (s)
            StIdle:   v = 5'b00001;
            StCool:   v = 5'b00010;
            StArmed:  v = 5'b00100;
            StActive: v = 5'b01000;
            StBroken: v = 5'b10000;
            default:  v = 5'b00001;
        endcase
        return v;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= StIdle;
            state_oh         <= 5'b00001;
            counter          <= 8'd0;
            top_monster_ctrl <= 1'b0;
            top_broken       <= 1'b0;
            spawn_count      <= 8'd0;
            kill_count       <= 8'd0;
        end else if ((state != StIdle) && !play_flag) begin
            state            <= StIdle;
            state_oh         <= onehot(StIdle);
            top_monster_ctrl <= 1'b0;
            top_broken       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (play_flag) begin
                        state       <= StCool;
                        state_oh    <= onehot(StCool);
                        counter     <= COOLDOWN_TICKS;
                        spawn_count <= 8'd0;
                        kill_count  <= 8'd0;
                    end
                end
                StCool: begin
                    if (tick) begin
                        if (counter == 8'd1) begin
                            state    <= StArmed;
                            state_oh <= onehot(StArmed);
                            counter  <= 8'd0;
                        end else begin
                            counter <= counter - 8'd1;
                        end
                    end
                end
                StArmed: begin
                    // lfsr here is the value present before this cycle's shift.
                    if (tick && spawn_hit) begin
                        state            <= StActive;
                        state_oh         <= onehot(StActive);
                        counter          <= TIMEOUT_TICKS;
                        top_monster_ctrl <= 1'b1;
                        spawn_count      <= spawn_inc;
                    end
                end
                StActive: begin
                    // A shot beats a coincident final timeout tick.
                    if (shoot) begin
                        state            <= StCool;
                        state_oh         <= onehot(StCool);
                        counter          <= COOLDOWN_TICKS;
                        top_monster_ctrl <= 1'b0;
                        kill_count       <= kill_inc;
                    end else if (tick) begin
                        if (counter == 8'd1) begin
                            state      <= StBroken;
                            state_oh   <= onehot(StBroken);
                            counter    <= 8'd0;
                            top_broken <= 1'b1;
                        end else begin
                            counter <= counter - 8'd1;
                        end
                    end
                end
                StBroken: begin
                    top_monster_ctrl <= 1'b1;
                    top_broken       <= 1'b1;
                end
                default: begin
                    state            <= StIdle;
                    state_oh         <= onehot(StIdle);
                    counter          <= 8'd0;
                    top_monster_ctrl <= 1'b0;
                    top_broken       <= 1'b0;
                end
            endcase
        end
    end

    assign q_MG_Idle   = state_oh[0];
    assign q_MG_Cool   = state_oh[1];
    assign q_MG_Armed  = state_oh[2];
    assign q_MG_Active = state_oh[3];
    assign q_MG_Broken = state_oh[4];

endmodule

// File: tb/tb_nexys_starship_monster_gen.sv
// Bench for nexys_starship_monster_gen: three instances (threshold 128, 256, 0) driven
// identically and compared every cycle against a rule-level model.
module tb_nexys_starship_monster_gen;

    localparam logic [7:0] CT = 8'd2;
    localparam logic [7:0] TT = 8'd3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       play_flag = 1'b0;
    logic       tick = 1'b0;
    logic       shoot = 1'b0;
    logic       ctrl [3];
    logic       brk [3];
    logic [7:0] sc [3];
    logic [7:0] kc [3];
    logic [4:0] oh [3];

    int checks = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    nexys_starship_monster_gen #(.SPAWN_THRESH(9'd128), .COOLDOWN_TICKS(CT), .TIMEOUT_TICKS(TT))
    dut_half (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .tick(tick), .shoot(shoot),
        .top_monster_ctrl(ctrl[0]), .top_broken(brk[0]), .spawn_count(sc[0]),
        .kill_count(kc[0]), .q_MG_Idle(oh[0][0]), .q_MG_Cool(oh[0][1]),
        .q_MG_Armed(oh[0][2]), .q_MG_Active(oh[0][3]), .q_MG_Broken(oh[0][4])
    );

    nexys_starship_monster_gen #(.SPAWN_THRESH(9'd256), .COOLDOWN_TICKS(CT), .TIMEOUT_TICKS(TT))
    dut_all (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .tick(tick), .shoot(shoot),
        .top_monster_ctrl(ctrl[1]), .top_broken(brk[1]), .spawn_count(sc[1]),
        .kill_count(kc[1]), .q_MG_Idle(oh[1][0]), .q_MG_Cool(oh[1][1]),
        .q_MG_Armed(oh[1][2]), .q_MG_Active(oh[1][3]), .q_MG_Broken(oh[1][4])
    );

    nexys_starship_monster_gen #(.SPAWN_THRESH(9'd0), .COOLDOWN_TICKS(CT), .TIMEOUT_TICKS(TT))
    dut_none (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .tick(tick), .shoot(shoot),
        .top_monster_ctrl(ctrl[2]), .top_broken(brk[2]), .spawn_count(sc[2]),
        .kill_count(kc[2]), .q_MG_Idle(oh[2][0]), .q_MG_Cool(oh[2][1]),
        .q_MG_Armed(oh[2][2]), .q_MG_Active(oh[2][3]), .q_MG_Broken(oh[2][4])
    );

    // Reference model: phase 0 idle, 1 cooldown, 2 armed, 3 active, 4 broken.
    int          ph [3];
    int          left [3];
    int          m_sp [3];
    int          m_kl [3];
    bit          m_ctrl [3];
    bit          m_brk [3];
    int          thr [3] = '{128, 256, 0};
    int unsigned m_lfsr;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ph[k] = 0; left[k] = 0; m_sp[k] = 0; m_kl[k] = 0;
            m_ctrl[k] = 0; m_brk[k] = 0;
        end
        m_lfsr = 32'hACE1;
    endtask

    task automatic model_step(input bit p, input bit t, input bit s);
        int unsigned fb;
        for (int k = 0; k < 3; k++) begin
            if (ph[k] != 0 && !p) begin
                ph[k] = 0; m_ctrl[k] = 0; m_brk[k] = 0;
            end else if (ph[k] == 0) begin
                if (p) begin ph[k] = 1; left[k] = int'(CT); m_sp[k] = 0; m_kl[k] = 0; end
            end else if (ph[k] == 1) begin
                if (t) begin
                    if (left[k] == 1) ph[k] = 2;
                    else left[k] = left[k] - 1;
                end
            end else if (ph[k] == 2) begin
                if (t && int'(m_lfsr % 256) < thr[k]) begin
                    ph[k] = 3; m_ctrl[k] = 1; left[k] = int'(TT);
                    m_sp[k] = (m_sp[k] < 255) ? m_sp[k] + 1 : 255;
                end
            end else if (ph[k] == 3) begin
                if (s) begin
                    ph[k] = 1; m_ctrl[k] = 0; left[k] = int'(CT);
                    m_kl[k] = (m_kl[k] < 255) ? m_kl[k] + 1 : 255;
                end else if (t) begin
                    if (left[k] == 1) begin ph[k] = 4; m_brk[k] = 1; end
                    else left[k] = left[k] - 1;
                end
            end
        end
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
    endtask

    function automatic logic [22:0] obs(input int k);
        return {ctrl[k], brk[k], sc[k], kc[k], oh[k]};
    endfunction

    function automatic logic [22:0] expv(input int k);
        return {m_ctrl[k], m_brk[k], 8'(m_sp[k]), 8'(m_kl[k]), 5'(1 << ph[k])};
    endfunction

    task automatic check(input string name, input int k, input logic [22:0] act,
                         input logic [22:0] want);
        checks++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h (ctrl,brk,spawn,kill,onehot)",
                     name, k, act, want);
        end
    endtask

    task automatic cycle(input bit p, input bit t, input bit s);
        play_flag = p; tick = t; shoot = s;
        @(posedge Clk);
        model_step(p, t, s);
        #1;
        for (int k = 0; k < 3; k++) check("model", k, obs(k), expv(k));
    endtask

    typedef struct {
        bit p; bit t; bit s;
        bit c; bit b; int sp; int kl; int st;
    } vec_t;
    vec_t tbl [$];

    int armed_ticks;
    int spawns;
    int n;
    bit was_armed;

    initial begin
        // Rows for the always-spawn instance: inputs, then ctrl, broken, spawn, kill, phase.
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 1, 0, 1, 0, 3});
        tbl.push_back('{1, 1, 0, 1, 0, 1, 0, 3});
        tbl.push_back('{1, 1, 0, 1, 0, 1, 0, 3});
        tbl.push_back('{1, 1, 1, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 1, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 1, 2});
        tbl.push_back('{1, 1, 0, 1, 0, 2, 1, 3});
        tbl.push_back('{1, 1, 0, 1, 0, 2, 1, 3});
        tbl.push_back('{1, 1, 0, 1, 0, 2, 1, 3});
        tbl.push_back('{1, 1, 0, 1, 1, 2, 1, 4});
        tbl.push_back('{1, 0, 1, 1, 1, 2, 1, 4});
        tbl.push_back('{1, 1, 1, 1, 1, 2, 1, 4});
        tbl.push_back('{0, 0, 0, 0, 0, 2, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 2, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 1, 0, 1, 0, 3});

        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        for (int k = 0; k < 3; k++) check("reset", k, obs(k), 23'b1);
        Reset = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].p, tbl[i].t, tbl[i].s);
            check($sformatf("vec%0d", i), 1, obs(1),
                  {tbl[i].c, tbl[i].b, 8'(tbl[i].sp), 8'(tbl[i].kl), 5'(1 << tbl[i].st)});
        end

        // Async reset while dut_all is active: outputs drop without a clock edge.
        Reset = 1'b1;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) check("async_reset", k, obs(k), 23'b1);
        #1;
        Reset = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(99) != 0, $urandom_range(2) == 0, $urandom_range(5) == 0);
        end

        // Long run: tick every cycle, shoot as soon as the half-rate instance shows a monster.
        cycle(0, 0, 0);
        armed_ticks = 0;
        spawns = 0;
        n = 0;
        while (armed_ticks < 10000 && n < 40000) begin
            was_armed = oh[0][2];
            if (was_armed) armed_ticks++;
            cycle(1, 1, ctrl[0]);
            if (was_armed && oh[0][3]) spawns++;
            n++;
        end
        checks++;
        if (armed_ticks < 10000) begin
            bad++;
            $display("FAIL armed_budget got=%0d armed ticks want=10000", armed_ticks);
        end
        checks++;
        if (spawns * 100 < armed_ticks * 47 || spawns * 100 > armed_ticks * 53) begin
            bad++;
            $display("FAIL spawn_rate got=%0d/%0d want 50%% +-3%%", spawns, armed_ticks);
        end
        check("spawn_saturate", 0, {15'd0, sc[0]}, 23'd255);
        check("kill_saturate", 0, {15'd0, kc[0]}, 23'd255);
        check("never_spawn", 2, {14'd0, ctrl[2], sc[2]}, 23'd0);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
